// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: per-channel period, high time and enable,
// with shadowed configuration applied glitch-free at period boundaries.
module clk_div_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 100,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;

  logic [31:0] ch_idx;
  logic        cfg_bad;
  logic        cfg_ok;
  logic        cfg_err_d;
  logic        cfg_err_q;

  // Index is widened so the range check stays meaningful for non power-of-two NUM_CH.
  always_comb begin
    ch_idx    = 32'(cfg_ch);
    cfg_bad   = (ch_idx >= $unsigned(NUM_CH)) ||
                (cfg_div < CNT_W'(2)) ||
                (cfg_high == '0) ||
                (cfg_high >= cfg_div);
    cfg_ok    = cfg_we && !cfg_bad;
    cfg_err_d = cfg_we && cfg_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [0:0]       st_q,    st_d;
      logic [CNT_W-1:0] cnt_q,   cnt_d;
      logic [CNT_W-1:0] div_q,   div_d;
      logic [CNT_W-1:0] high_q,  high_d;
      logic [CNT_W-1:0] sdiv_q,  sdiv_d;
      logic [CNT_W-1:0] shigh_q, shigh_d;
      logic             pend_q,  pend_d;
      logic             out_q,   out_d;
      logic             tick_q,  tick_d;
      logic [CNT_W-1:0] cnt_inc;
      logic             wrap;
      logic             apply;
      logic             wr;

      always_comb begin
        wr      = cfg_ok && (ch_idx == $unsigned(gi));
        cnt_inc = (cnt_q == div_q - 1'b1) ? '0 : cnt_q + 1'b1;
        wrap    = (cnt_inc == '0);
        st_d    = st_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        apply   = 1'b0;
        if (!ch_en[gi]) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
          out_d = 1'b0;
          apply = (st_q == ST_IDLE);
        end else if ((st_q == ST_IDLE) || sync_start) begin
          // Channel start and sync restart both begin a fresh period at phase 0.
          st_d   = ST_RUN;
          cnt_d  = '0;
          out_d  = 1'b1;
          tick_d = 1'b1;
          apply  = 1'b1;
        end else begin
          cnt_d  = cnt_inc;
          apply  = wrap;
          tick_d = wrap;
          out_d  = wrap ? 1'b1 : (cnt_inc < high_q);
        end

        div_d   = div_q;
        high_d  = high_q;
        pend_d  = pend_q;
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        if (apply && pend_q) begin
          div_d  = sdiv_q;
          high_d = shigh_q;
          pend_d = 1'b0;
        end
        // A write landing on an apply edge becomes the next pending value.
        if (wr) begin
          sdiv_d  = cfg_div;
          shigh_d = cfg_high;
          pend_d  = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q    <= ST_IDLE;
          cnt_q   <= '0;
          div_q   <= DEF_DIV;
          high_q  <= DEF_HIGH;
          sdiv_q  <= DEF_DIV;
          shigh_q <= DEF_HIGH;
          pend_q  <= 1'b0;
          out_q   <= 1'b0;
          tick_q  <= 1'b0;
        end else begin
          st_q    <= st_d;
          cnt_q   <= cnt_d;
          div_q   <= div_d;
          high_q  <= high_d;
          sdiv_q  <= sdiv_d;
          shigh_q <= shigh_d;
          pend_q  <= pend_d;
          out_q   <= out_d;
          tick_q  <= tick_d;
        end
      end

      assign clk_out[gi] = out_q;
      assign tick[gi]    = tick_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: directed stimulus pushes expected tick/cfg_err
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_clk_div_gen;

  localparam int NCH = 3;

  typedef struct {
    int cyc;
    int hw;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_en = '0;
  logic           sync_start = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [15:0]    cfg_div = '0;
  logic [15:0]    cfg_high = '0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic           cfg_err;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t tq[NCH][$];
  int  eq[$];
  bit  hi_act[NCH];
  int  hi_start[NCH];
  int  hi_exp[NCH];

  clk_div_gen #(.NUM_CH(NCH), .CNT_W(16), .DEFAULT_DIV(100)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .sync_start(sync_start),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
    .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic until_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic push_tick(input int ch, input int c, input int w);
    ev_t e;
    e.cyc = c;
    e.hw  = w;
    tq[ch].push_back(e);
  endtask

  task automatic push_run(input int ch, input int first, input int step, input int n, input int w);
    for (int i = 0; i < n; i++) push_tick(ch, first + i * step, w);
  endtask

  task automatic write_cfg(input int ch, input int d, input int h);
    $display("cycle %0d: write ch=%0d div=%0d high=%0d", cyc, ch, d, h);
    cfg_we   = 1'b1;
    cfg_ch   = ch[1:0];
    cfg_div  = d[15:0];
    cfg_high = h[15:0];
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every tick and cfg_err pulse is a transaction matched against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) hi_act[ch] = 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (tick[ch]) begin
          if (hi_act[ch] && hi_exp[ch] != 0) begin
            checks++;
            errors++;
            $display("FAIL high_width ch%0d: no fall before tick at cycle %0d, required width %0d",
                     ch, cyc, hi_exp[ch]);
          end
          checks++;
          if (tq[ch].size() == 0) begin
            errors++;
            hi_act[ch] = 1'b0;
            $display("FAIL tick_unexpected ch%0d: actual tick at cycle %0d required none", ch, cyc);
          end else begin
            ev_t e;
            e = tq[ch].pop_front();
            if (e.cyc != cyc) begin
              errors++;
              $display("FAIL tick_cycle ch%0d: actual %0d required %0d", ch, cyc, e.cyc);
            end else begin
              $display("tick ch%0d at cycle %0d as expected", ch, cyc);
            end
            checks++;
            if (clk_out[ch] !== 1'b1) begin
              errors++;
              $display("FAIL clk_at_tick ch%0d: actual %b required 1", ch, clk_out[ch]);
            end
            hi_act[ch]   = 1'b1;
            hi_start[ch] = cyc;
            hi_exp[ch]   = e.hw;
          end
        end else if (hi_act[ch] && !clk_out[ch]) begin
          hi_act[ch] = 1'b0;
          if (hi_exp[ch] != 0) begin
            checks++;
            if (cyc - hi_start[ch] != hi_exp[ch]) begin
              errors++;
              $display("FAIL high_width ch%0d: actual %0d required %0d", ch,
                       cyc - hi_start[ch], hi_exp[ch]);
            end
          end
        end
      end
      if (cfg_err) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL cfg_err_unexpected: actual pulse at cycle %0d required none", cyc);
        end else begin
          int c;
          c = eq.pop_front();
          if (c != cyc) begin
            errors++;
            $display("FAIL cfg_err_cycle: actual %0d required %0d", cyc, c);
          end else begin
            $display("cfg_err at cycle %0d as expected", cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    until_cyc(2);
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_cfg_err", int'(cfg_err), 0);

    // Default channel: period 100, 50 high.
    until_cyc(3);
    push_run(0, 4, 100, 2, 50);
    rst_n = 1'b1;
    ch_en = 3'b001;

    // Reconfigure mid-period: current period finishes, then 2 high / 3 low.
    until_cyc(10);
    push_tick(1, 11, 50);
    ch_en[1] = 1'b1;
    until_cyc(41);
    push_run(1, 111, 5, 5, 2);
    write_cfg(1, 5, 2);

    // Rejected writes.
    until_cyc(120);
    eq.push_back(121);
    write_cfg(0, 1, 1);
    until_cyc(122);
    eq.push_back(123);
    write_cfg(0, 8, 0);
    until_cyc(124);
    eq.push_back(125);
    write_cfg(0, 8, 8);
    until_cyc(126);
    eq.push_back(127);
    write_cfg(3, 8, 2);

    // Two channels out of phase, then sync_start aligns them.
    until_cyc(130);
    push_run(0, 204, 4, 6, 2);
    push_tick(0, 228, 0);
    write_cfg(0, 4, 2);
    until_cyc(132);
    push_run(1, 136, 6, 16, 3);
    write_cfg(1, 6, 3);
    until_cyc(229);
    push_run(0, 230, 4, 4, 2);
    push_run(1, 230, 6, 3, 3);
    sync_start = 1'b1;
    @(negedge clk);
    sync_start = 1'b0;
    until_cyc(245);
    ch_en = 3'b000;

    // Disable mid-high, configure while idle, re-enable.
    until_cyc(250);
    push_tick(2, 251, 10);
    ch_en[2] = 1'b1;
    until_cyc(260);
    ch_en[2] = 1'b0;
    until_cyc(265);
    write_cfg(2, 10, 3);
    until_cyc(270);
    push_run(2, 271, 10, 2, 3);
    push_tick(2, 291, 0);
    ch_en[2] = 1'b1;

    // Async reset mid-high with a write pending.
    until_cyc(291);
    write_cfg(2, 20, 5);
    eq.push_back(293);
    write_cfg(0, 1, 1);
    chk("pre_reset_clk_out2", int'(clk_out[2]), 1);
    chk("pre_reset_cfg_err", int'(cfg_err), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clk_out", int'(clk_out), 0);
    chk("async_reset_tick", int'(tick), 0);
    chk("async_reset_cfg_err", int'(cfg_err), 0);
    until_cyc(297);
    push_run(2, 298, 100, 2, 50);
    rst_n = 1'b1;
    until_cyc(455);
    ch_en = 3'b000;

    until_cyc(462);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("ticks_left_ch%0d", ch), tq[ch].size(), 0);
    chk("cfg_err_left", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesizable, multi-channel programmable clock generator. It is the parametrised successor to the free-running behavioural testbench clock source.
- Derives NUM_CH divided clock outputs from one system clock. Each channel has its own run-time period, high-time (duty) and enable, plus a one-cycle tick marking each rising edge.
- Sits between the system clock and peripheral/bench logic that needs slower, phase-aligned clocks or clock enables.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16).
- CNT_W, 16, width of the period/high-time counters and config fields.
- DEFAULT_DIV, 100, period in clk cycles loaded into every channel at reset (2..2^CNT_W-1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ch_en  input  NUM_CH  per-channel run enable, level-sensitive.
- sync_start  input  1  single-cycle pulse; restarts all enabled channels at phase 0.
- cfg_we  input  1  config write strobe, one cycle.
- cfg_ch  input  max(1,$clog2(NUM_CH))  channel index for the write.
- cfg_div  input  CNT_W  new period in clk cycles.
- cfg_high  input  CNT_W  new high-time in clk cycles.
- clk_out  output  NUM_CH  divided clock per channel, registered.
- tick  output  NUM_CH  one-cycle pulse in the cycle clk_out rises.
- cfg_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async assert, sync release):
  - Every channel: active div = DEFAULT_DIV, active high = DEFAULT_DIV/2, cnt = 0, pending = 0.
  - clk_out = 0, tick = 0, cfg_err = 0.
- Per-channel state: IDLE (ch_en = 0) and RUN.
  - IDLE: cnt held at 0, clk_out = 0, tick = 0.
  - IDLE->RUN on the edge where ch_en is sampled 1. That same edge loads cnt = 0, clk_out = 1, tick = 1 (one cycle of latency from ch_en).
  - RUN->IDLE on the edge where ch_en is sampled 0. clk_out = 0 from that edge, even mid-high phase; no completion of the current period.
- RUN counting:
  - cnt_next = (cnt == div-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < high).
  - tick <= (cnt_next == 0).
  - Result: exactly high cycles of 1 and div-high cycles of 0 per period, period = div cycles.
- Config validation, checked in the cycle cfg_we = 1. The write is rejected and cfg_err pulses the next cycle if any of:
  - cfg_ch >= NUM_CH
  - cfg_div < 2
  - cfg_high == 0
  - cfg_high >= cfg_div
- A rejected write leaves all state unchanged.
- Accepted write: the values go to the channel's shadow registers and pending is set.
  - A second write before the pending write is applied overwrites the shadow (last write wins).
- Shadow->active apply (clears pending), glitch-free, at the first of:
  - (a) period wrap: the edge where cnt_next == 0 in RUN;
  - (b) any edge while the channel is IDLE;
  - (c) a sync_start edge.
- When applied at a wrap, the new div/high govern the period starting with that edge: the clk_out value loaded at the wrap edge is 1, and high is taken from the new value.
- Simultaneous cfg_we and apply event on the same channel: the apply uses the previous shadow; the new write becomes pending.
- sync_start:
  - Every channel in RUN loads cnt = 0, clk_out = 1, tick = 1 on that edge, after applying any pending config.
  - IDLE channels are unaffected.
  - sync_start has priority over a normal wrap on the same edge.
- sync_start and a ch_en rise on the same edge: the channel starts at phase 0 (both rules give the same result).
- Reset mid-operation: all outputs go to 0 immediately and asynchronously. Pending writes are discarded; active config returns to the defaults.
- All counters are unsigned CNT_W-bit. No arithmetic overflow is possible because div <= 2^CNT_W-1.

Test Plan:
1. Reset release, ch_en=0001 held, DEFAULT_DIV=100 -> ch0 clk_out rises one cycle after ch_en; 50 high / 50 low, period 100; tick every 100 cycles; other channels stay 0.
2. ch1 running div=100, write cfg_ch=1 div=5 high=2 at cnt=30 -> the current 100-cycle period completes unchanged, then a repeating 2 high / 3 low pattern with a tick each rise.
3. Invalid writes: div=1; high=0; high=div=8; cfg_ch=NUM_CH -> cfg_err pulses one cycle after each write; the waveform is unchanged.
4. ch0 div=4 high=2, ch1 div=6 high=3, both running out of phase, pulse sync_start -> both tick and rise on the same edge; ch1 rises again at +6 cycles and ch0 at +4 cycles, both next coinciding at +12.
5. Drop ch_en[2] during the high phase -> clk_out[2]=0 on the next edge; a write applied while IDLE takes effect, and re-enabling starts the new period at phase 0.
6. Assert rst_n=0 asynchronously mid-high with a write pending -> clk_out/tick/cfg_err go to 0 immediately; after release the channel runs with DEFAULT_DIV, not the pending value.
